// File: rtl/packer_pkg.sv
// Shared types and helpers for the width_packer block.
package packer_pkg;

  localparam int unsigned PACKER_IN_WIDTH = 8;
  localparam int unsigned PACKER_RATIO    = 4;

  // Width of the lane counter for a given lanes-per-word ratio.
  function automatic int unsigned cnt_width(input int unsigned ratio);
    return (ratio < 2) ? 1 : $clog2(ratio);
  endfunction

  // Output word bundle carried through the output holding register.
  typedef struct packed {
    logic [PACKER_IN_WIDTH*PACKER_RATIO-1:0] data;
    logic [PACKER_RATIO-1:0]                 keep;
    logic                                    last;
  } out_word_t;

endpackage

// File: rtl/width_packer_out_slice.sv
// Single-entry valid/ready holding register for the packed output word.
module out_slice
  import packer_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      load_c,
  input  out_word_t word_in,
  input  logic      out_rdy,
  output logic      out_val,
  output out_word_t word_out
);

  // Load a new word, drain on ready, otherwise hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_val  <= 1'b0;
      word_out <= '0;
    end else if (load_c) begin
      out_val  <= 1'b1;
      word_out <= word_in;
    end else if (out_rdy) begin
      out_val  <= 1'b0;
    end
  end

endmodule

// File: rtl/width_packer.sv
// Packs RATIO narrow beats into one wide word with per-lane keep and last.
// Optional idle flush of partial words: define PACKER_IDLE_FLUSH_EN.
// Bundle widths follow the packer_pkg defaults for IN_WIDTH and RATIO.
module width_packer
  import packer_pkg::*;
#(
  parameter int unsigned IN_WIDTH    = PACKER_IN_WIDTH,
  parameter int unsigned RATIO       = PACKER_RATIO,
  parameter int unsigned IDLE_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [IN_WIDTH-1:0]       data_in,
  input  logic                      data_in_val,
  input  logic                      data_in_last,
  output logic                      data_in_rdy,
  output logic [IN_WIDTH*RATIO-1:0] data_out,
  output logic [RATIO-1:0]          data_out_keep,
  output logic                      data_out_last,
  output logic                      data_out_val,
  input  logic                      data_out_rdy
);

  localparam int unsigned CW = cnt_width(RATIO);
  localparam int unsigned WW = IN_WIDTH * RATIO;

  logic [WW-1:0]    acc_q, acc_d;
  logic [RATIO-1:0] keep_q, keep_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic             pend_last_q, pend_last_d;

  logic             accept_c;
  logic             out_free_c;
  logic             complete_c;
  logic             flush_c;
  logic             load_c;
  logic [WW-1:0]    beat_data_c;
  logic [RATIO-1:0] beat_keep_c;
  out_word_t        load_word_c;
  out_word_t        out_word;

  // Input is blocked only while a finished word waits for the output register.
  assign data_in_rdy = !pend_q && !reset;
  assign accept_c    = data_in_val && data_in_rdy;
  assign out_free_c  = !data_out_val || data_out_rdy;
  assign complete_c  = accept_c && ((cnt_q == CW'(RATIO - 1)) || data_in_last);

  // Accumulator image with the incoming beat written into lane cnt.
  always_comb begin
    beat_data_c = acc_q;
    beat_keep_c = keep_q;
    for (int unsigned k = 0; k < RATIO; k++) begin
      if (cnt_q == CW'(k)) begin
        beat_data_c[k*IN_WIDTH +: IN_WIDTH] = data_in;
        beat_keep_c[k]                      = 1'b1;
      end
    end
  end

`ifdef PACKER_IDLE_FLUSH_EN
  localparam int unsigned IW = $clog2(IDLE_CYCLES + 1);

  logic [IW-1:0] idle_q, idle_d;

  // Idle counter: cleared by any accepted beat, counts while a partial word sits.
  always_comb begin
    idle_d  = idle_q;
    flush_c = 1'b0;
    if (accept_c) begin
      idle_d = '0;
    end else if ((cnt_q != '0) && !pend_q) begin
      if (idle_q == IW'(IDLE_CYCLES)) begin
        flush_c = 1'b1;
      end else begin
        idle_d = idle_q + IW'(1);
      end
    end
  end

  // Idle counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_d;
    end
  end
`else
  assign flush_c = 1'b0;
`endif

  // Next-state for accumulator, lane count and pending word; selects output load.
  always_comb begin
    acc_d            = acc_q;
    keep_d           = keep_q;
    cnt_d            = cnt_q;
    pend_d           = pend_q;
    pend_last_d      = pend_last_q;
    load_c           = 1'b0;
    load_word_c.data = acc_q;
    load_word_c.keep = keep_q;
    load_word_c.last = pend_last_q;

    if (pend_q) begin
      if (data_out_rdy) begin
        load_c      = 1'b1;
        acc_d       = '0;
        keep_d      = '0;
        cnt_d       = '0;
        pend_d      = 1'b0;
        pend_last_d = 1'b0;
      end
    end else if (complete_c || flush_c) begin
      if (complete_c) begin
        load_word_c.data = beat_data_c;
        load_word_c.keep = beat_keep_c;
        load_word_c.last = data_in_last;
      end else begin
        load_word_c.last = 1'b0;
      end
      if (out_free_c) begin
        load_c = 1'b1;
        acc_d  = '0;
        keep_d = '0;
        cnt_d  = '0;
      end else begin
        acc_d       = load_word_c.data;
        keep_d      = load_word_c.keep;
        pend_d      = 1'b1;
        pend_last_d = load_word_c.last;
      end
    end else if (accept_c) begin
      acc_d  = beat_data_c;
      keep_d = beat_keep_c;
      cnt_d  = cnt_q + CW'(1);
    end
  end

  // Accumulator state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q       <= '0;
      keep_q      <= '0;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      pend_last_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      keep_q      <= keep_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      pend_last_q <= pend_last_d;
    end
  end

  out_slice u_out_slice (
    .clk      (clk),
    .reset    (reset),
    .load_c   (load_c),
    .word_in  (load_word_c),
    .out_rdy  (data_out_rdy),
    .out_val  (data_out_val),
    .word_out (out_word)
  );

  assign data_out      = out_word.data;
  assign data_out_keep = out_word.keep;
  assign data_out_last = out_word.last;

endmodule

// File: tb/tb_width_packer.sv
// Directed testbench for width_packer (IN_WIDTH=8, RATIO=4).
module tb_width_packer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  data_in = 8'h00;
  logic        data_in_val = 1'b0;
  logic        data_in_last = 1'b0;
  logic        data_in_rdy;
  logic [31:0] data_out;
  logic [3:0]  data_out_keep;
  logic        data_out_last;
  logic        data_out_val;
  logic        data_out_rdy = 1'b0;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  width_packer dut (
    .clk           (clk),
    .reset         (reset),
    .data_in       (data_in),
    .data_in_val   (data_in_val),
    .data_in_last  (data_in_last),
    .data_in_rdy   (data_in_rdy),
    .data_out      (data_out),
    .data_out_keep (data_out_keep),
    .data_out_last (data_out_last),
    .data_out_val  (data_out_val),
    .data_out_rdy  (data_out_rdy)
  );

  task automatic beat(input logic [7:0] d, input logic l);
    data_in = d; data_in_val = 1'b1; data_in_last = l;
    @(posedge clk); #1;
  endtask

  task automatic idle_cyc();
    data_in = 8'hEE; data_in_val = 1'b0; data_in_last = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #1;
    vecs++; if (data_out_val !== 1'b0) begin $display("FAIL rst_val: got %b want 0", data_out_val); errs++; end
    vecs++; if (data_out !== 32'h0) begin $display("FAIL rst_data: got %h want 00000000", data_out); errs++; end
    vecs++; if (data_out_keep !== 4'h0) begin $display("FAIL rst_keep: got %b want 0000", data_out_keep); errs++; end
    vecs++; if (data_out_last !== 1'b0) begin $display("FAIL rst_last: got %b want 0", data_out_last); errs++; end
    vecs++; if (data_in_rdy !== 1'b0) begin $display("FAIL rst_rdy: got %b want 0", data_in_rdy); errs++; end
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    vecs++; if (data_in_rdy !== 1'b1) begin $display("FAIL rst_release_rdy: got %b want 1", data_in_rdy); errs++; end
  endtask

  task automatic test_full_word();
    logic [7:0] b [4];
    b = '{8'h11, 8'h22, 8'h33, 8'h44};
    data_out_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      beat(b[i], 1'b0);
      if (i < 3) begin
        vecs++; if (data_out_val !== 1'b0) begin $display("FAIL full_early_val beat %0d: got %b want 0", i, data_out_val); errs++; end
      end
    end
    vecs++; if (data_out_val !== 1'b1) begin $display("FAIL full_val: got %b want 1", data_out_val); errs++; end
    vecs++; if (data_out !== 32'h44332211) begin $display("FAIL full_data: got %h want 44332211", data_out); errs++; end
    vecs++; if (data_out_keep !== 4'b1111) begin $display("FAIL full_keep: got %b want 1111", data_out_keep); errs++; end
    vecs++; if (data_out_last !== 1'b0) begin $display("FAIL full_last: got %b want 0", data_out_last); errs++; end
    idle_cyc();
    vecs++; if (data_out_val !== 1'b0) begin $display("FAIL full_val_one_cycle: got %b want 0", data_out_val); errs++; end
  endtask

  task automatic test_partial_last();
    data_out_rdy = 1'b1;
    beat(8'hAA, 1'b0);
    beat(8'hBB, 1'b1);
    vecs++; if (data_out !== 32'h0000BBAA) begin $display("FAIL part_data: got %h want 0000bbaa", data_out); errs++; end
    vecs++; if (data_out_keep !== 4'b0011) begin $display("FAIL part_keep: got %b want 0011", data_out_keep); errs++; end
    vecs++; if (data_out_last !== 1'b1) begin $display("FAIL part_last: got %b want 1", data_out_last); errs++; end
    beat(8'hCC, 1'b0);
    vecs++; if (data_out_val !== 1'b0) begin $display("FAIL part_drain_val: got %b want 0", data_out_val); errs++; end
    beat(8'hDD, 1'b0);
    beat(8'hEE, 1'b0);
    beat(8'hFF, 1'b0);
    vecs++; if (data_out !== 32'hFFEEDDCC) begin $display("FAIL part_next_data: got %h want ffeeddcc", data_out); errs++; end
    vecs++; if (data_out_last !== 1'b0) begin $display("FAIL part_next_last: got %b want 0", data_out_last); errs++; end
    beat(8'h5A, 1'b1);
    vecs++; if (data_out !== 32'h0000005A) begin $display("FAIL single_data: got %h want 0000005a", data_out); errs++; end
    vecs++; if (data_out_keep !== 4'b0001) begin $display("FAIL single_keep: got %b want 0001", data_out_keep); errs++; end
    beat(8'h31, 1'b0);
    beat(8'h32, 1'b0);
    beat(8'h33, 1'b0);
    beat(8'h34, 1'b1);
    vecs++; if (data_out !== 32'h34333231) begin $display("FAIL full_last_data: got %h want 34333231", data_out); errs++; end
    vecs++; if (data_out_keep !== 4'b1111) begin $display("FAIL full_last_keep: got %b want 1111", data_out_keep); errs++; end
    vecs++; if (data_out_last !== 1'b1) begin $display("FAIL full_last_last: got %b want 1", data_out_last); errs++; end
    idle_cyc();
  endtask

  task automatic test_backpressure();
    data_out_rdy = 1'b0;
    beat(8'h01, 1'b0);
    beat(8'h02, 1'b0);
    beat(8'h03, 1'b0);
    beat(8'h04, 1'b0);
    vecs++; if (data_out !== 32'h04030201) begin $display("FAIL bp_first_data: got %h want 04030201", data_out); errs++; end
    beat(8'h05, 1'b0);
    beat(8'h06, 1'b0);
    beat(8'h07, 1'b0);
    vecs++; if (data_in_rdy !== 1'b1) begin $display("FAIL bp_rdy_before: got %b want 1", data_in_rdy); errs++; end
    beat(8'h08, 1'b0);
    vecs++; if (data_in_rdy !== 1'b0) begin $display("FAIL bp_rdy_drop: got %b want 0", data_in_rdy); errs++; end
    beat(8'h99, 1'b0);
    beat(8'h99, 1'b0);
    vecs++; if (data_out !== 32'h04030201) begin $display("FAIL bp_hold_data: got %h want 04030201", data_out); errs++; end
    vecs++; if (data_out_val !== 1'b1) begin $display("FAIL bp_hold_val: got %b want 1", data_out_val); errs++; end
    vecs++; if (data_in_rdy !== 1'b0) begin $display("FAIL bp_hold_rdy: got %b want 0", data_in_rdy); errs++; end
    data_out_rdy = 1'b1;
    idle_cyc();
    vecs++; if (data_out !== 32'h08070605) begin $display("FAIL bp_second_data: got %h want 08070605", data_out); errs++; end
    vecs++; if (data_out_val !== 1'b1) begin $display("FAIL bp_second_val: got %b want 1", data_out_val); errs++; end
    vecs++; if (data_in_rdy !== 1'b1) begin $display("FAIL bp_rdy_back: got %b want 1", data_in_rdy); errs++; end
    data_out_rdy = 1'b0;
    idle_cyc();
    vecs++; if (data_out !== 32'h08070605) begin $display("FAIL bp_second_hold: got %h want 08070605", data_out); errs++; end
    data_out_rdy = 1'b1;
    idle_cyc();
    vecs++; if (data_out_val !== 1'b0) begin $display("FAIL bp_empty_val: got %b want 0", data_out_val); errs++; end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_w [4];
    exp_w = '{32'h13121110, 32'h17161514, 32'h1B1A1918, 32'h1F1E1D1C};
    data_out_rdy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      vecs++; if (data_in_rdy !== 1'b1) begin $display("FAIL b2b_rdy beat %0d: got %b want 1", i, data_in_rdy); errs++; end
      beat(8'(16 + i), 1'b0);
      if ((i % 4) == 3) begin
        vecs++; if (data_out_val !== 1'b1 || data_out !== exp_w[i/4]) begin
          $display("FAIL b2b_word %0d: got val=%b data=%h want val=1 data=%h", i/4, data_out_val, data_out, exp_w[i/4]); errs++;
        end
      end else begin
        vecs++; if (data_out_val !== 1'b0) begin $display("FAIL b2b_gap beat %0d: got %b want 0", i, data_out_val); errs++; end
      end
    end
    idle_cyc();
  endtask

  task automatic test_reset_mid_word();
    data_out_rdy = 1'b0;
    beat(8'h21, 1'b0);
    beat(8'h22, 1'b0);
    beat(8'h23, 1'b0);
    beat(8'h24, 1'b0);
    vecs++; if (data_out !== 32'h24232221) begin $display("FAIL mid_pre_data: got %h want 24232221", data_out); errs++; end
    beat(8'hDE, 1'b0);
    beat(8'hAD, 1'b0);
    data_in_val = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    vecs++; if (data_out_val !== 1'b0) begin $display("FAIL mid_rst_val: got %b want 0", data_out_val); errs++; end
    vecs++; if (data_out !== 32'h0) begin $display("FAIL mid_rst_data: got %h want 00000000", data_out); errs++; end
    vecs++; if (data_out_keep !== 4'h0) begin $display("FAIL mid_rst_keep: got %b want 0000", data_out_keep); errs++; end
    vecs++; if (data_in_rdy !== 1'b0) begin $display("FAIL mid_rst_rdy: got %b want 0", data_in_rdy); errs++; end
    #2;
    reset = 1'b0;
    data_out_rdy = 1'b1;
    beat(8'h55, 1'b0);
    beat(8'h66, 1'b0);
    beat(8'h77, 1'b0);
    vecs++; if (data_out_val !== 1'b0) begin $display("FAIL mid_new_early: got %b want 0", data_out_val); errs++; end
    beat(8'h88, 1'b0);
    vecs++; if (data_out !== 32'h88776655) begin $display("FAIL mid_new_data: got %h want 88776655", data_out); errs++; end
    vecs++; if (data_out_keep !== 4'b1111) begin $display("FAIL mid_new_keep: got %b want 1111", data_out_keep); errs++; end
  endtask

  task automatic test_idle();
    data_out_rdy = 1'b1;
    beat(8'h01, 1'b0);
    beat(8'h02, 1'b0);
    beat(8'h03, 1'b0);
`ifdef PACKER_IDLE_FLUSH_EN
    begin
      logic seen;
      int   n;
      seen = 1'b0;
      n = 0;
      for (int k = 0; k < 40 && !seen; k++) begin
        idle_cyc();
        n = k + 1;
        seen = data_out_val;
      end
      vecs++; if (seen !== 1'b1) begin $display("FAIL idle_timeout: got no word after %0d cycles want flush", n); errs++; end
      vecs++; if (n < 16) begin $display("FAIL idle_early: got flush after %0d cycles want at least 16", n); errs++; end
      vecs++; if (data_out !== 32'h00030201) begin $display("FAIL idle_data: got %h want 00030201", data_out); errs++; end
      vecs++; if (data_out_keep !== 4'b0111) begin $display("FAIL idle_keep: got %b want 0111", data_out_keep); errs++; end
      vecs++; if (data_out_last !== 1'b0) begin $display("FAIL idle_last: got %b want 0", data_out_last); errs++; end
    end
`else
    for (int k = 0; k < 30; k++) begin
      idle_cyc();
      vecs++; if (data_out_val !== 1'b0) begin $display("FAIL idle_no_flush cycle %0d: got %b want 0", k, data_out_val); errs++; end
    end
    beat(8'h04, 1'b1);
    vecs++; if (data_out !== 32'h04030201) begin $display("FAIL idle_resume_data: got %h want 04030201", data_out); errs++; end
    vecs++; if (data_out_keep !== 4'b1111) begin $display("FAIL idle_resume_keep: got %b want 1111", data_out_keep); errs++; end
    vecs++; if (data_out_last !== 1'b1) begin $display("FAIL idle_resume_last: got %b want 1", data_out_last); errs++; end
`endif
    idle_cyc();
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_partial_last();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_word();
    test_idle();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/width_packer.md
Name: width_packer

Overview:
- Sits directly downstream of the byte FIFO and consumes its `data_out`/`data_out_val`/`data_out_rdy` stream.
- Packs RATIO narrow beats into one wide word for the wide-datapath consumer.
- Handles partial words terminated by a `last` marker, with per-lane keep bits.
- Uses the same valid/ready handshake on both sides and sustains full throughput: 1 input beat per cycle.

Parameters:
- IN_WIDTH, 8, width of one input beat (lane).
- RATIO, 4, lanes per output word; must be 2 or more.
- IDLE_CYCLES, 16, idle-flush threshold; used only when PACKER_IDLE_FLUSH_EN is defined.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- data_in  in  IN_WIDTH  input beat.
- data_in_val  in  1  input beat valid.
- data_in_last  in  1  beat ends the current packet; qualified by data_in_val.
- data_in_rdy  out  1  packer can accept a beat.
- data_out  out  IN_WIDTH*RATIO  packed word; lane k = bits [k*IN_WIDTH +: IN_WIDTH].
- data_out_keep  out  RATIO  lane-valid mask.
- data_out_last  out  1  word ends a packet.
- data_out_val  out  1  output word valid.
- data_out_rdy  in  1  consumer accepts word.

Behaviour:
- Reset is asynchronous and active-high: clk is the single clock, reset clears all state immediately, no clock needed.
- Values held while reset is asserted:
  - data_out_val=0, data_out=0, data_out_keep=0, data_out_last=0.
  - data_in_rdy=0.
  - Lane count cnt=0, pending flag pend=0, accumulator=0.
- Reset mid-word discards any partial word silently.
- data_in_rdy = !pend && !reset. It is registered-state only: no combinational path from data_in_val, data_in_last or data_out_rdy.
- An input beat is accepted when data_in_val && data_in_rdy. The beat is written to accumulator lane cnt, and keep bit cnt is set.
- Lane order: the first beat goes to the lowest lane (little-endian). Unused lanes of a partial word read 0.
- Completing beat = accepted beat with cnt==RATIO-1 or data_in_last=1.
  - If the output register is free (!data_out_val || data_out_rdy): the word, keep and last load into the output register the same edge. data_out_val=1 on the next cycle (latency 1). cnt returns to 0.
  - Otherwise the word stays in the accumulator, pend=1, and data_in_rdy drops to 0.
- Non-completing accepted beat: cnt increments.
- While pend=1: the accumulator moves to the output register on the first cycle data_out_rdy=1, in the same edge as the old word drains. data_out_val stays 1, then pend=0 and cnt=0.
- Output hold: while data_out_val && !data_out_rdy, data_out/keep/last are stable.
- Output register empties when data_out_rdy=1 and nothing new is loaded.
- data_in_last on the RATIO-th beat gives a full keep mask (all ones) with last=1.
- Back-to-back packets are never merged into one word.
- Steady state with data_out_rdy=1 and continuous input: no input stall, one word every RATIO cycles.
- data_in contents are ignored when data_in_val=0.

Optional Feature:
- Macro: PACKER_IDLE_FLUSH_EN.
- Defined:
  - An idle counter resets on every accepted beat.
  - It increments while cnt>0, pend=0 and no beat is accepted.
  - On reaching IDLE_CYCLES, the partial word is treated as completed with last=0 and normal output-register rules apply.
  - The counter saturates and resets on reset.
- Undefined: no counter; partial words wait indefinitely for further beats or last.

Decomposition:
- Package packer_pkg holds:
  - localparam helper function for count width, $clog2(RATIO).
  - a typedef struct for the output word bundle: data, keep, last.
- One natural sub-module: out_slice, a single-entry valid/ready holding register taking that struct. width_packer instantiates it for the output stage.

Test Plan:
- RATIO=4, data_out_rdy=1, beats 0x11,0x22,0x33,0x44 on consecutive cycles -> one cycle after 4th accept: data_out=0x44332211, keep=4'b1111, last=0, val high exactly 1 cycle.
- Beats 0xAA, then 0xBB with last=1 -> data_out=0x0000BBAA, keep=4'b0011, last=1; next packet starts in lane 0.
- data_out_rdy=0 holding a word, send 4 more beats -> data_in_rdy=0 after 4th; data_out unchanged. Then data_out_rdy=1 for 1 cycle -> second word presented the next cycle; data_in_rdy=1 again.
- Continuous input of 16 beats with data_out_rdy=1 -> data_in_rdy never drops; 4 words out, one every 4 cycles, data matching in order.
- Assert reset after 2 beats accepted -> outputs zero immediately, with no clock edge needed. After release, 4 new beats yield a word containing only the new bytes.
- With PACKER_IDLE_FLUSH_EN, IDLE_CYCLES=16: 3 beats 0x01,0x02,0x03 then idle -> after 16 idle cycles data_out=0x00030201, keep=4'b0111, last=0.
